// File: rtl/synth_pkg.sv
// Shared defaults, FSM state type and latched-request layout for voice_allocator.
package synth_pkg;

    localparam int NUM_VOICES_DEFAULT = 6;
    localparam int FREQ_W_DEFAULT     = 12;
    localparam int VOL_W_DEFAULT      = 4;

    // Request fields are sized for the widest supported build; narrower
    // instances zero-extend into them so one struct serves every configuration.
    localparam int FREQ_W_MAX = 32;
    localparam int VOL_W_MAX  = 16;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SCAN   = 2'd1,
        UPDATE = 2'd2
    } alloc_state_e;

    typedef struct packed {
        logic                  on;
        logic [FREQ_W_MAX-1:0] freq;
        logic [VOL_W_MAX-1:0]  vol;
    } alloc_req_t;

endpackage

// File: rtl/voice_age_tracker.sv
// Per-slot saturating age counters; reports the oldest active slot so a full
// voice table can reuse the longest-held voice.
module voice_age_tracker
    import synth_pkg::*;
#(
    parameter int NUM_VOICES = NUM_VOICES_DEFAULT
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          clear_all,
    input  logic                          wr_en,
    input  logic [$clog2(NUM_VOICES)-1:0] wr_idx,
    input  logic [NUM_VOICES-1:0]         active,
    output logic [$clog2(NUM_VOICES)-1:0] oldest_idx
);
    localparam int IDX_W = $clog2(NUM_VOICES);
    localparam int AGE_W = $clog2(NUM_VOICES) + 1;

    logic [NUM_VOICES-1:0][AGE_W-1:0] age_q, age_d;
    logic [AGE_W-1:0]                 best_age;

    always_comb begin
        age_d = age_q;
        if (clear_all) begin
            age_d = '0;
        end else if (wr_en) begin
            for (int i = 0; i < NUM_VOICES; i++) begin
                if (IDX_W'(i) == wr_idx) begin
                    age_d[i] = '0;
                end else if (active[i] && age_q[i] != '1) begin
                    age_d[i] = age_q[i] + 1'b1;
                end
            end
        end
    end

    // Strict compare keeps the lowest index when ages tie.
    always_comb begin
        oldest_idx = '0;
        best_age   = '0;
        for (int i = 0; i < NUM_VOICES; i++) begin
            if (active[i] && age_q[i] > best_age) begin
                best_age   = age_q[i];
                oldest_idx = IDX_W'(i);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            age_q <= '0;
        end else begin
            age_q <= age_d;
        end
    end

endmodule

// File: rtl/voice_allocator.sv
// Polyphonic voice allocator: latches a note request, scans the slot table one
// entry per cycle, then applies it in UPDATE. Define VOICE_ALLOC_STEAL_EN to let
// a note-on take over the oldest voice when every slot is busy.
module voice_allocator
    import synth_pkg::*;
#(
    parameter int NUM_VOICES = NUM_VOICES_DEFAULT,
    parameter int FREQ_W     = FREQ_W_DEFAULT,
    parameter int VOL_W      = VOL_W_DEFAULT
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         req_valid,
    output logic                         req_ready,
    input  logic                         req_on,
    input  logic [FREQ_W-1:0]            req_freq,
    input  logic [VOL_W-1:0]             req_vol,
    input  logic                         all_off,
    output logic [NUM_VOICES-1:0]        play,
    output logic [NUM_VOICES*FREQ_W-1:0] freqs,
    output logic [NUM_VOICES*VOL_W-1:0]  volume,
    output logic                         stolen,
    output logic                         dropped
);
    localparam int IDX_W  = $clog2(NUM_VOICES);
    localparam int SCAN_W = $clog2(NUM_VOICES + 1);
`ifdef VOICE_ALLOC_STEAL_EN
    localparam bit STEAL_EN = 1'b1;
`else
    localparam bit STEAL_EN = 1'b0;
`endif

    alloc_state_e                      state_q, state_d;
    logic [SCAN_W-1:0]                 scan_idx_q, scan_idx_d;
    alloc_req_t                        req_q, req_d;
    logic                              match_found_q, match_found_d;
    logic                              free_found_q, free_found_d;
    logic [IDX_W-1:0]                  match_idx_q, match_idx_d;
    logic [IDX_W-1:0]                  free_idx_q, free_idx_d;
    logic [NUM_VOICES-1:0]             play_q, play_d;
    logic [NUM_VOICES-1:0][FREQ_W-1:0] freqs_q, freqs_d;
    logic [NUM_VOICES-1:0][VOL_W-1:0]  vol_q, vol_d;
    logic                              stolen_q, stolen_d;
    logic                              dropped_q, dropped_d;

    logic [IDX_W-1:0] slot, wr_idx, oldest_idx;
    logic             age_wr, note_on;

    assign slot      = IDX_W'(scan_idx_q);
    assign note_on   = req_q.on && (req_q.vol != '0);
    assign wr_idx    = match_found_q ? match_idx_q : (free_found_q ? free_idx_q : oldest_idx);
    assign req_ready = (state_q == IDLE) && !all_off;

    voice_age_tracker #(.NUM_VOICES(NUM_VOICES)) u_age_tracker (
        .clk        (clk),
        .reset      (reset),
        .clear_all  (all_off),
        .wr_en      (age_wr),
        .wr_idx     (wr_idx),
        .active     (play_q),
        .oldest_idx (oldest_idx)
    );

    // NOTE: every *_d starts from its hold value so no path can infer a latch.
    always_comb begin
        state_d       = state_q;
        scan_idx_d    = scan_idx_q;
        req_d         = req_q;
        match_found_d = match_found_q;
        free_found_d  = free_found_q;
        match_idx_d   = match_idx_q;
        free_idx_d    = free_idx_q;
        play_d        = play_q;
        freqs_d       = freqs_q;
        vol_d         = vol_q;
        stolen_d      = 1'b0;
        dropped_d     = 1'b0;
        age_wr        = 1'b0;

        if (all_off) begin
            state_d    = IDLE;
            scan_idx_d = '0;
            play_d     = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (req_valid) begin
                        state_d       = SCAN;
                        scan_idx_d    = '0;
                        req_d.on      = req_on;
                        req_d.freq    = FREQ_W_MAX'(req_freq);
                        req_d.vol     = VOL_W_MAX'(req_vol);
                        match_found_d = 1'b0;
                        free_found_d  = 1'b0;
                    end
                end
                SCAN: begin
                    // The count runs one step past the last slot before UPDATE.
                    if (scan_idx_q == SCAN_W'(NUM_VOICES)) begin
                        state_d = UPDATE;
                    end else begin
                        if (play_q[slot] && !match_found_q
                            && FREQ_W_MAX'(freqs_q[slot]) == req_q.freq) begin
                            match_found_d = 1'b1;
                            match_idx_d   = slot;
                        end
                        if (!play_q[slot] && !free_found_q) begin
                            free_found_d = 1'b1;
                            free_idx_d   = slot;
                        end
                        scan_idx_d = scan_idx_q + 1'b1;
                    end
                end
                UPDATE: begin
                    state_d    = IDLE;
                    scan_idx_d = '0;
                    if (note_on) begin
                        if (match_found_q || free_found_q || STEAL_EN) begin
                            age_wr          = 1'b1;
                            play_d[wr_idx]  = 1'b1;
                            freqs_d[wr_idx] = req_q.freq[FREQ_W-1:0];
                            vol_d[wr_idx]   = req_q.vol[VOL_W-1:0];
                            stolen_d        = !match_found_q && !free_found_q;
                        end else begin
                            dropped_d = 1'b1;
                        end
                    end else if (match_found_q) begin
                        play_d[match_idx_q] = 1'b0;
                    end else begin
                        dropped_d = 1'b1;
                    end
                end
                default: begin
                    state_d    = IDLE;
                    scan_idx_d = '0;
                end
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments only; the slot
    // table is plain flops, so it resets alongside the control state.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= IDLE;
            scan_idx_q    <= '0;
            req_q         <= '0;
            match_found_q <= 1'b0;
            free_found_q  <= 1'b0;
            match_idx_q   <= '0;
            free_idx_q    <= '0;
            play_q        <= '0;
            freqs_q       <= '0;
            vol_q         <= '0;
            stolen_q      <= 1'b0;
            dropped_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            scan_idx_q    <= scan_idx_d;
            req_q         <= req_d;
            match_found_q <= match_found_d;
            free_found_q  <= free_found_d;
            match_idx_q   <= match_idx_d;
            free_idx_q    <= free_idx_d;
            play_q        <= play_d;
            freqs_q       <= freqs_d;
            vol_q         <= vol_d;
            stolen_q      <= stolen_d;
            dropped_q     <= dropped_d;
        end
    end

    assign play    = play_q;
    assign freqs   = freqs_q;
    assign volume  = vol_q;
    assign stolen  = stolen_q;
    assign dropped = dropped_q;

endmodule

// File: tb/tb_voice_allocator.sv
// Scoreboard bench for voice_allocator: stimulus pushes the expected result of
// each request, a negedge monitor compares all outputs every cycle.
module tb_voice_allocator;
    localparam int NUM_VOICES = 6;
    localparam int FREQ_W     = 12;
    localparam int VOL_W      = 4;
    localparam int LATENCY    = NUM_VOICES + 2;
    localparam int AGE_MAX    = (1 << ($clog2(NUM_VOICES) + 1)) - 1;
`ifdef VOICE_ALLOC_STEAL_EN
    localparam bit STEAL = 1'b1;
`else
    localparam bit STEAL = 1'b0;
`endif

    logic                         clk = 1'b0;
    logic                         reset = 1'b1;
    logic                         req_valid = 1'b0;
    logic                         req_ready;
    logic                         req_on = 1'b0;
    logic [FREQ_W-1:0]            req_freq = '0;
    logic [VOL_W-1:0]             req_vol = '0;
    logic                         all_off = 1'b0;
    logic [NUM_VOICES-1:0]        play;
    logic [NUM_VOICES*FREQ_W-1:0] freqs;
    logic [NUM_VOICES*VOL_W-1:0]  volume;
    logic                         stolen;
    logic                         dropped;

    voice_allocator dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_on    (req_on),
        .req_freq  (req_freq),
        .req_vol   (req_vol),
        .all_off   (all_off),
        .play      (play),
        .freqs     (freqs),
        .volume    (volume),
        .stolen    (stolen),
        .dropped   (dropped)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int                           start;
        int                           due;
        logic [NUM_VOICES-1:0]        play;
        logic [NUM_VOICES*FREQ_W-1:0] freqs;
        logic [NUM_VOICES*VOL_W-1:0]  vol;
        bit                           stolen;
        bit                           dropped;
    } exp_t;

    exp_t sb[$];
    exp_t cur;
    bit   mon_en = 1'b0;
    int   tests_run = 0;
    int   failures = 0;

    // Reference model: the voice table as plain arrays.
    bit                m_play[NUM_VOICES];
    logic [FREQ_W-1:0] m_freq[NUM_VOICES];
    logic [VOL_W-1:0]  m_vol[NUM_VOICES];
    int                m_age[NUM_VOICES];

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        tests_run++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
        end
    endtask

    function automatic void snapshot(output exp_t e);
        e = '{default: '0};
        for (int i = 0; i < NUM_VOICES; i++) begin
            e.play[i]                    = m_play[i];
            e.freqs[i*FREQ_W +: FREQ_W] = m_freq[i];
            e.vol[i*VOL_W +: VOL_W]     = m_vol[i];
        end
    endfunction

    function automatic void model_reset(output exp_t e);
        for (int i = 0; i < NUM_VOICES; i++) begin
            m_play[i] = 1'b0; m_freq[i] = '0; m_vol[i] = '0; m_age[i] = 0;
        end
        snapshot(e);
    endfunction

    function automatic void model_all_off(output exp_t e);
        for (int i = 0; i < NUM_VOICES; i++) begin
            m_play[i] = 1'b0; m_age[i] = 0;
        end
        snapshot(e);
    endfunction

    function automatic void model_request(input bit on, input logic [FREQ_W-1:0] f,
                                          input logic [VOL_W-1:0] v, output exp_t e);
        int  hit = -1, free_slot = -1, tgt = -1;
        bit  st = 1'b0, dr = 1'b0;
        for (int i = NUM_VOICES - 1; i >= 0; i--) begin
            if (m_play[i] && m_freq[i] == f) hit = i;
            if (!m_play[i]) free_slot = i;
        end
        if (on && v != 0) begin
            if (hit >= 0) tgt = hit;
            else if (free_slot >= 0) tgt = free_slot;
            else if (STEAL) begin
                tgt = 0;
                for (int i = 1; i < NUM_VOICES; i++) if (m_age[i] > m_age[tgt]) tgt = i;
                st = 1'b1;
            end else dr = 1'b1;
            if (tgt >= 0) begin
                for (int i = 0; i < NUM_VOICES; i++)
                    if (i != tgt && m_play[i] && m_age[i] < AGE_MAX) m_age[i]++;
                m_age[tgt] = 0; m_play[tgt] = 1'b1; m_freq[tgt] = f; m_vol[tgt] = v;
            end
        end else if (hit >= 0) m_play[hit] = 1'b0;
        else dr = 1'b1;
        snapshot(e);
        e.stolen  = st;
        e.dropped = dr;
    endfunction

    // Monitor: every negedge compares outputs against the expected picture.
    always @(negedge clk) begin
        bit exp_st, exp_dr, busy;
        if (mon_en) begin
            exp_st = 1'b0;
            exp_dr = 1'b0;
            if (sb.size() > 0 && sb[0].due < cyc) begin
                check("overdue_entry", 128'(cyc), 128'(sb[0].due));
                void'(sb.pop_front());
            end
            if (sb.size() > 0 && sb[0].due == cyc) begin
                cur    = sb.pop_front();
                exp_st = cur.stolen;
                exp_dr = cur.dropped;
            end
            busy = sb.size() > 0 && cyc >= sb[0].start;
            check("play", 128'(play), 128'(cur.play));
            check("freqs", 128'(freqs), 128'(cur.freqs));
            check("volume", 128'(volume), 128'(cur.vol));
            check("stolen", 128'(stolen), 128'(exp_st));
            check("dropped", 128'(dropped), 128'(exp_dr));
            check("req_ready", 128'(req_ready), 128'(!busy && !all_off));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_until(input int c);
        while (cyc < c) tick();
    endtask

    // Normal request; with hold, req_valid stays high and the payload churns.
    task automatic do_req(input bit on, input logic [FREQ_W-1:0] f,
                          input logic [VOL_W-1:0] v, input bit hold);
        exp_t e;
        req_valid = 1'b1; req_on = on; req_freq = f; req_vol = v;
        model_request(on, f, v, e);
        e.start = cyc + 1;
        e.due   = e.start + LATENCY;
        sb.push_back(e);
        tick();
        if (hold) begin
            while (cyc < e.due) begin
                req_on   = 1'($urandom);
                req_freq = FREQ_W'($urandom);
                req_vol  = VOL_W'($urandom);
                tick();
            end
        end
        req_valid = 1'b0;
        wait_until(e.due);
        tick();
    endtask

    // Request interrupted k edges after transfer by all_off (use_reset=0) or reset.
    task automatic do_abort(input bit on, input logic [FREQ_W-1:0] f,
                            input logic [VOL_W-1:0] v, input int k, input bit use_reset);
        exp_t e;
        req_valid = 1'b1; req_on = on; req_freq = f; req_vol = v;
        if (use_reset) model_reset(e);
        else model_all_off(e);
        e.start = cyc + 1;
        e.due   = e.start + k;
        sb.push_back(e);
        tick();
        req_valid = 1'b0;
        wait_until(e.due - 1);
        if (use_reset) reset = 1'b1;
        else all_off = 1'b1;
        tick();
        reset   = 1'b0;
        all_off = 1'b0;
        tick();
    endtask

    task automatic do_all_off_idle(input bit with_req);
        exp_t e;
        all_off   = 1'b1;
        req_valid = with_req;
        req_on    = 1'b1;
        req_freq  = 12'h3AA;
        req_vol   = 4'd7;
        model_all_off(e);
        e.start = cyc + 1;
        e.due   = cyc + 1;
        sb.push_back(e);
        tick();
        all_off   = 1'b0;
        req_valid = 1'b0;
        tick();
    endtask

    initial begin
        exp_t e;
        int   r, k;
        bit   on;
        logic [FREQ_W-1:0] f;
        logic [VOL_W-1:0]  v;

        model_reset(e);
        cur = e;
        repeat (3) tick();
        reset  = 1'b0;
        mon_en = 1'b1;
        tick();

        // First note, volume rewrite, unmatched off, vol-0 off.
        do_req(1'b1, 12'h100, 4'd5, 1'b0);
        do_req(1'b1, 12'h100, 4'd9, 1'b0);
        do_req(1'b0, 12'h300, 4'd0, 1'b0);
        do_req(1'b1, 12'h100, 4'd0, 1'b0);

        // Full table, then one more distinct note-on.
        do_all_off_idle(1'b0);
        for (int i = 0; i < NUM_VOICES; i++) do_req(1'b1, FREQ_W'(12'h101 + i), 4'd3, 1'b0);
        do_req(1'b1, 12'h200, 4'd7, 1'b0);

        // Three voices, then all_off three cycles into SCAN of a new note.
        do_all_off_idle(1'b0);
        for (int i = 0; i < 3; i++) do_req(1'b1, FREQ_W'(12'h140 + i), 4'd6, 1'b0);
        do_abort(1'b1, 12'h150, 4'd4, 3, 1'b0);

        // Payload churn while busy, all_off against a transfer, reset mid-scan.
        do_req(1'b1, 12'h2C0, 4'd8, 1'b1);
        do_all_off_idle(1'b1);
        do_req(1'b1, 12'h111, 4'd2, 1'b0);
        do_abort(1'b1, 12'h122, 4'd3, 4, 1'b1);
        do_req(1'b1, 12'h133, 4'd4, 1'b0);

        for (int n = 0; n < 300; n++) begin
            r  = int'($urandom_range(0, 24));
            on = ($urandom_range(0, 2) != 0);
            f  = FREQ_W'(12'h100 + $urandom_range(0, 8));
            v  = VOL_W'($urandom_range(0, 15));
            k  = int'($urandom_range(1, LATENCY));
            if (r == 0) do_all_off_idle(1'($urandom));
            else if (r == 1) do_abort(on, f, v, k, 1'b0);
            else if (r == 2) do_abort(on, f, v, k, 1'b1);
            else do_req(on, f, v, r == 3);
        end

        repeat (3) tick();
        check("scoreboard_drained", 128'(sb.size()), 128'(0));
        $display("[TB] %0d tests run, %0d failed", tests_run, failures);
        $finish;
    end

endmodule
